fc_argmax_classifier: RTL

Final classification stage placed directly downstream of the last FC layer wrapper (fc3). It snapshots the layer's parallel signed accumulator outputs (logits) when the layer's valid pulse arrives. It then scans the logits sequentially, one comparison per cycle, and emits the winning class index and its logit with a one-cycle valid pulse. A ready/drop indication covers vectors that arrive while a scan is in progress.

---
 rtl/fc_argmax_classifier.sv | 122 ++++++++++++
 1 files changed

// File: rtl/fc_argmax_classifier.sv
// Argmax stage after the last FC layer: snapshots the logits, scans one per cycle,
// and reports the winning index and value with a one-cycle valid pulse.
module fc_argmax_classifier #(
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned ACC_WIDTH   = 32,
  localparam int unsigned IDX_WIDTH  = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        valid_in,
  input  logic signed [ACC_WIDTH-1:0] logits_in [NUM_CLASSES],
  output logic                        ready_out,
  output logic        [IDX_WIDTH-1:0] class_idx,
  output logic signed [ACC_WIDTH-1:0] max_logit,
  output logic                        valid_out,
  output logic                        dropped
);

  localparam logic [IDX_WIDTH-1:0] LastIdx = IDX_WIDTH'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e state_q, state_d;

  logic signed [ACC_WIDTH-1:0] logit_buf_q [NUM_CLASSES];
  logic signed [ACC_WIDTH-1:0] best_val_q;
  logic        [IDX_WIDTH-1:0] best_idx_q;
  logic        [IDX_WIDTH-1:0] scan_idx_q;
  logic        [IDX_WIDTH-1:0] class_idx_q;
  logic signed [ACC_WIDTH-1:0] max_logit_q;
  logic                        dropped_q;

  logic signed [ACC_WIDTH-1:0] cand;
  logic                        cand_wins;
  logic signed [ACC_WIDTH-1:0] next_best_val;
  logic        [IDX_WIDTH-1:0] next_best_idx;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (valid_in) begin
          state_d = (NUM_CLASSES == 1) ? StDone : StScan;
        end
      end
      StScan: begin
        if (scan_idx_q == LastIdx) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    ready_out = (state_q == StIdle);
    valid_out = (state_q == StDone);
  end

  // Strict > keeps the lowest index among equal maxima.
  always_comb begin
    cand          = logit_buf_q[scan_idx_q];
    cand_wins     = (cand > best_val_q);
    next_best_val = cand_wins ? cand : best_val_q;
    next_best_idx = cand_wins ? scan_idx_q : best_idx_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      logit_buf_q <= '{default: '0};
      best_val_q  <= '0;
      best_idx_q  <= '0;
      scan_idx_q  <= '0;
      class_idx_q <= '0;
      max_logit_q <= '0;
      dropped_q   <= 1'b0;
    end else begin
      dropped_q <= valid_in && (state_q != StIdle);
      unique case (state_q)
        StIdle: begin
          if (valid_in) begin
            logit_buf_q <= logits_in;
            best_val_q  <= logits_in[0];
            best_idx_q  <= '0;
            scan_idx_q  <= IDX_WIDTH'(1);
            if (NUM_CLASSES == 1) begin
              class_idx_q <= '0;
              max_logit_q <= logits_in[0];
            end
          end
        end
        StScan: begin
          best_val_q <= next_best_val;
          best_idx_q <= next_best_idx;
          scan_idx_q <= scan_idx_q + IDX_WIDTH'(1);
          if (scan_idx_q == LastIdx) begin
            class_idx_q <= next_best_idx;
            max_logit_q <= next_best_val;
          end
        end
        default: ;
      endcase
    end
  end

  assign class_idx = class_idx_q;
  assign max_logit = max_logit_q;
  assign dropped   = dropped_q;

endmodule
